// File: rtl/kr580_port_hub.sv
// kr580_port_hub: memory-mapped I/O hub for a KR580-class CPU.
// Provides CHANNELS byte-wide output latches and synchronized input bytes.
// Adds a masked, edge-triggered interrupt controller with a priority vector
// and a free-running CPU clock-enable divider.
module kr580_port_hub #(
  parameter int unsigned CHANNELS = 4,
  parameter logic [7:0]  BASE     = 8'h10,
  parameter int unsigned DIV_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            pin_pa,
  input  logic [7:0]            pin_po,
  input  logic                  pin_pw,
  output logic [7:0]            pin_pi,
  output logic                  pin_intr,
  output logic                  clk_ce,
  input  logic [CHANNELS*8-1:0] ext_in,
  output logic [CHANNELS*8-1:0] ext_out,
  input  logic [CHANNELS-1:0]   irq_src
);

  localparam int unsigned EXT_W    = CHANNELS * 8;
  localparam logic [7:0]  OFF_MASK = 8'h08;
  localparam logic [7:0]  OFF_PEND = 8'h09;
  localparam logic [7:0]  OFF_VEC  = 8'h0A;

  // Register-file offset relative to the block base; BASE is 16-aligned so
  // addresses below BASE wrap to large offsets and decode as unmapped.
  logic [7:0] offset_c;
  assign offset_c = pin_pa - BASE;

  // Synchronizer and edge-detect state.
  logic [EXT_W-1:0]    ext_s1, ext_s2;
  logic [CHANNELS-1:0] irq_s1, irq_s2, irq_s3;

  // Control/status state.
  logic                pw_q;
  logic [CHANNELS-1:0] mask_q, pend_q;
  logic [DIV_LOG2-1:0] div_q;

  // Next-state and decode signals.
  logic                wr_fire_c;
  logic [CHANNELS-1:0] irq_rise_c;
  logic [CHANNELS-1:0] active_c;
  logic [CHANNELS-1:0] mask_d, pend_d;
  logic [EXT_W-1:0]    ext_out_d;
  logic [7:0]          vec_c;
  logic [7:0]          rd_data_c;
  logic [DIV_LOG2-1:0] div_inc_c;

  // A write commits only on the rising edge of the (level) strobe.
  assign wr_fire_c  = pin_pw & ~pw_q;
  assign irq_rise_c = irq_s2 & ~irq_s3;
  assign active_c   = pend_q & mask_q;
  assign div_inc_c  = div_q + DIV_LOG2'(1);

  // Write decode: output latches, mask load and pending W1C (set wins).
  always_comb begin
    ext_out_d = ext_out;
    mask_d    = mask_q;
    pend_d    = pend_q;
    if (wr_fire_c) begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        if (offset_c == 8'(k)) begin
          ext_out_d[k*8 +: 8] = pin_po;
        end
      end
      if (offset_c == OFF_MASK) begin
        mask_d = pin_po[CHANNELS-1:0];
      end
      if (offset_c == OFF_PEND) begin
        pend_d = pend_q & ~pin_po[CHANNELS-1:0];
      end
    end
    pend_d = pend_d | irq_rise_c;
  end

  // Interrupt vector: lowest-numbered active source, 8'hFF when none.
  always_comb begin
    vec_c = 8'hFF;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (active_c[i]) begin
        vec_c = 8'(i);
      end
    end
  end

  // Read mux; unmapped offsets and data offsets beyond CHANNELS return 8'hFF.
  always_comb begin
    rd_data_c = 8'hFF;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (offset_c == 8'(k)) begin
        rd_data_c = ext_s2[k*8 +: 8];
      end
    end
    if (offset_c == OFF_MASK) begin
      rd_data_c = 8'(mask_q);
    end
    if (offset_c == OFF_PEND) begin
      rd_data_c = 8'(pend_q);
    end
    if (offset_c == OFF_VEC) begin
      rd_data_c = vec_c;
    end
  end

  // Two-flop synchronizers plus the previous-sample flop for irq edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_s1 <= '0;
      ext_s2 <= '0;
      irq_s1 <= '0;
      irq_s2 <= '0;
      irq_s3 <= '0;
    end else begin
      ext_s1 <= ext_in;
      ext_s2 <= ext_s1;
      irq_s1 <= irq_src;
      irq_s2 <= irq_s1;
      irq_s3 <= irq_s2;
    end
  end

  // Register file, strobe history and CPU-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pw_q     <= 1'b0;
      ext_out  <= '0;
      mask_q   <= '0;
      pend_q   <= '0;
      pin_pi   <= 8'hFF;
      pin_intr <= 1'b0;
    end else begin
      pw_q     <= pin_pw;
      ext_out  <= ext_out_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      pin_pi   <= rd_data_c;
      pin_intr <= |active_c;
    end
  end

  // Divider: clk_ce is high exactly while the counter holds all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      clk_ce <= 1'b0;
    end else begin
      div_q  <= div_inc_c;
      clk_ce <= (div_inc_c == '1);
    end
  end

endmodule

// File: tb/tb_kr580_port_hub.sv
// Directed self-checking bench for kr580_port_hub with default parameters.
module tb_kr580_port_hub;

  logic        clk;
  logic        rst;
  logic [7:0]  pin_pa;
  logic [7:0]  pin_po;
  logic        pin_pw;
  logic [7:0]  pin_pi;
  logic        pin_intr;
  logic        clk_ce;
  logic [31:0] ext_in;
  logic [31:0] ext_out;
  logic [3:0]  irq_src;

  int n_checks;
  int n_fail;

  kr580_port_hub #(.CHANNELS(4), .BASE(8'h10), .DIV_LOG2(2)) dut (
    .clk(clk), .rst(rst), .pin_pa(pin_pa), .pin_po(pin_po), .pin_pw(pin_pw),
    .pin_pi(pin_pi), .pin_intr(pin_intr), .clk_ce(clk_ce),
    .ext_in(ext_in), .ext_out(ext_out), .irq_src(irq_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete strobe: one cycle high, one cycle low.
  task automatic do_write(input logic [7:0] pa, input logic [7:0] po);
    pin_pa = pa;
    pin_po = po;
    pin_pw = 1'b1;
    tick();
    pin_pw = 1'b0;
    tick();
  endtask

  // Pulse one irq source long enough to pass the synchronizer and edge detector.
  task automatic pulse_irq(input int idx);
    irq_src[idx] = 1'b1;
    repeat (3) tick();
    irq_src[idx] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (ext_out !== 32'h0) begin n_fail++; $display("FAIL reset_ext_out: got %h expected %h", ext_out, 32'h0); end
    n_checks++;
    if (pin_pi !== 8'hFF) begin n_fail++; $display("FAIL reset_pin_pi: got %h expected %h", pin_pi, 8'hFF); end
    n_checks++;
    if (pin_intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %b expected 0", pin_intr); end
    n_checks++;
    if (clk_ce !== 1'b0) begin n_fail++; $display("FAIL reset_clk_ce: got %b expected 0", clk_ce); end
  endtask

  // Reset release; clk_ce must pulse in cycles 4, 8, 12 after release.
  task automatic test_divider();
    logic exp_ce;
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_ce = ((i % 4) == 3);
      n_checks++;
      if (clk_ce !== exp_ce) begin
        n_fail++;
        $display("FAIL divider_cycle_%0d: got %b expected %b", i + 1, clk_ce, exp_ce);
      end
    end
  endtask

  task automatic test_write_hold();
    pin_pa = 8'h12;
    pin_po = 8'hA5;
    pin_pw = 1'b1;
    tick();
    n_checks++;
    if (ext_out !== 32'h00A5_0000) begin n_fail++; $display("FAIL write_first: got %h expected %h", ext_out, 32'h00A5_0000); end
    tick();
    pin_po = 8'h00;
    repeat (3) tick();
    n_checks++;
    if (ext_out !== 32'h00A5_0000) begin n_fail++; $display("FAIL write_held: got %h expected %h", ext_out, 32'h00A5_0000); end
    pin_pw = 1'b0;
    tick();
    n_checks++;
    if (ext_out !== 32'h00A5_0000) begin n_fail++; $display("FAIL write_release: got %h expected %h", ext_out, 32'h00A5_0000); end
  endtask

  task automatic test_back_to_back();
    do_write(8'h10, 8'h11);
    do_write(8'h13, 8'h44);
    n_checks++;
    if (ext_out !== 32'h44A5_0011) begin n_fail++; $display("FAIL back_to_back: got %h expected %h", ext_out, 32'h44A5_0011); end
  endtask

  task automatic test_read();
    ext_in = 32'h0000_3C00;
    pin_pa = 8'h11;
    repeat (3) tick();
    n_checks++;
    if (pin_pi !== 8'h3C) begin n_fail++; $display("FAIL read_ch1: got %h expected %h", pin_pi, 8'h3C); end
    pin_pa = 8'h15;
    tick();
    n_checks++;
    if (pin_pi !== 8'hFF) begin n_fail++; $display("FAIL read_unmapped_15: got %h expected %h", pin_pi, 8'hFF); end
    pin_pa = 8'h05;
    tick();
    n_checks++;
    if (pin_pi !== 8'hFF) begin n_fail++; $display("FAIL read_below_base: got %h expected %h", pin_pi, 8'hFF); end
    pin_pa = 8'h13;
    tick();
    n_checks++;
    if (pin_pi !== 8'h00) begin n_fail++; $display("FAIL read_ch3: got %h expected %h", pin_pi, 8'h00); end
  endtask

  task automatic test_unmapped_write();
    do_write(8'h14, 8'h55);
    do_write(8'h1A, 8'h55);
    do_write(8'h1F, 8'h55);
    do_write(8'h05, 8'h55);
    n_checks++;
    if (ext_out !== 32'h44A5_0011) begin n_fail++; $display("FAIL unmapped_ext_out: got %h expected %h", ext_out, 32'h44A5_0011); end
    pin_pa = 8'h18;
    tick();
    n_checks++;
    if (pin_pi !== 8'h00) begin n_fail++; $display("FAIL unmapped_mask: got %h expected %h", pin_pi, 8'h00); end
  endtask

  task automatic test_irq();
    do_write(8'h18, 8'h0C);
    pulse_irq(3);
    pulse_irq(2);
    pin_pa = 8'h19;
    tick();
    n_checks++;
    if (pin_pi !== 8'h0C) begin n_fail++; $display("FAIL irq_pend: got %h expected %h", pin_pi, 8'h0C); end
    pin_pa = 8'h1A;
    tick();
    n_checks++;
    if (pin_pi !== 8'h02) begin n_fail++; $display("FAIL irq_vec_2: got %h expected %h", pin_pi, 8'h02); end
    n_checks++;
    if (pin_intr !== 1'b1) begin n_fail++; $display("FAIL irq_intr_set: got %b expected 1", pin_intr); end
    do_write(8'h19, 8'h04);
    pin_pa = 8'h1A;
    tick();
    n_checks++;
    if (pin_pi !== 8'h03) begin n_fail++; $display("FAIL irq_vec_3: got %h expected %h", pin_pi, 8'h03); end
    do_write(8'h19, 8'h08);
    n_checks++;
    if (pin_intr !== 1'b0) begin n_fail++; $display("FAIL irq_intr_clear: got %b expected 0", pin_intr); end
    pin_pa = 8'h1A;
    tick();
    n_checks++;
    if (pin_pi !== 8'hFF) begin n_fail++; $display("FAIL irq_vec_none: got %h expected %h", pin_pi, 8'hFF); end
  endtask

  task automatic test_masked();
    do_write(8'h18, 8'h00);
    pulse_irq(0);
    pin_pa = 8'h19;
    tick();
    n_checks++;
    if (pin_intr !== 1'b0) begin n_fail++; $display("FAIL masked_intr: got %b expected 0", pin_intr); end
    n_checks++;
    if (pin_pi !== 8'h01) begin n_fail++; $display("FAIL masked_pend: got %h expected %h", pin_pi, 8'h01); end
    pin_pa = 8'h18;
    pin_po = 8'h01;
    pin_pw = 1'b1;
    tick();
    n_checks++;
    if (pin_intr !== 1'b0) begin n_fail++; $display("FAIL unmask_same_cycle: got %b expected 0", pin_intr); end
    pin_pw = 1'b0;
    tick();
    n_checks++;
    if (pin_intr !== 1'b1) begin n_fail++; $display("FAIL unmask_next_cycle: got %b expected 1", pin_intr); end
  endtask

  // irq_src[1] edge lands on the same clock as a W1C of bit 1.
  task automatic test_set_wins();
    irq_src[1] = 1'b1;
    tick();
    tick();
    pin_pa = 8'h19;
    pin_po = 8'h02;
    pin_pw = 1'b1;
    tick();
    pin_pw = 1'b0;
    tick();
    n_checks++;
    if (pin_pi !== 8'h03) begin n_fail++; $display("FAIL set_wins_pend: got %h expected %h", pin_pi, 8'h03); end
    irq_src[1] = 1'b0;
    do_write(8'h19, 8'h02);
    tick();
    n_checks++;
    if (pin_pi !== 8'h01) begin n_fail++; $display("FAIL w1c_after_set: got %h expected %h", pin_pi, 8'h01); end
  endtask

  task automatic test_reset_mid_write();
    rst    = 1'b1;
    pin_pa = 8'h10;
    pin_po = 8'h77;
    pin_pw = 1'b1;
    tick();
    n_checks++;
    if (ext_out !== 32'h0) begin n_fail++; $display("FAIL rst_mid_write: got %h expected %h", ext_out, 32'h0); end
    n_checks++;
    if (pin_intr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_intr: got %b expected 0", pin_intr); end
    rst = 1'b0;
    tick();
    n_checks++;
    if (ext_out !== 32'h0000_0077) begin n_fail++; $display("FAIL held_strobe_after_rst: got %h expected %h", ext_out, 32'h0000_0077); end
    pin_pw = 1'b0;
    tick();
    n_checks++;
    if (ext_out !== 32'h0000_0077) begin n_fail++; $display("FAIL after_rst_release: got %h expected %h", ext_out, 32'h0000_0077); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    pin_pa   = 8'h00;
    pin_po   = 8'h00;
    pin_pw   = 1'b0;
    ext_in   = 32'h0;
    irq_src  = 4'h0;
    #1;
    test_reset();
    test_divider();
    test_write_hold();
    test_back_to_back();
    test_read();
    test_unmapped_write();
    test_irq();
    test_masked();
    test_set_wins();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
